seg7_scan_ctrl: RTL

Time-multiplexing scheduler for the shared seven-segment display bus. Cycles one digit at a time across NUM_DIGITS common anodes and inserts a blanking gap between digits to prevent ghosting. Digit values are double-buffered behind a load/ack handshake so that updates land only on frame boundaries. Sits between the counter/datapath logic that produces BCD/hex digits and the board pins; contains its own slot prescaler on the system clock.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/hex_to_seg7.sv | 9 +
 rtl/seg7_scan_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, scan state encoding and width helper for seg7_scan_ctrl
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: nibble to active-high {g,f,e,d,c,b,a} glyph
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_GLYPH[nib_i];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scanner with blanking gaps and frame-aligned double buffering
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    cin,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);
  localparam int IW = clog2(NUM_DIGITS);
  localparam int CW = clog2(TICK_DIV);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] stage_q, stage_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic pending_q, pending_d;
  logic slot_end, blank_end, boundary, all_zero, drive, dp_d;
  logic [NUM_DIGITS-1:0] lz_mask, an_d;
  logic [6:0] glyph, seg_d;
  hex_to_seg7 u_dec (.nib_i(shadow_q[4*idx_d +: 4]), .seg_o(glyph));
  always_comb begin
    slot_end  = cnt_q == CW'(TICK_DIV - 1);
    blank_end = cnt_q == CW'(BLANK_CYCLES - 1);
    boundary  = enable && (state_q == IDLE ||
                (state_q == DRIVE && slot_end && idx_q == IW'(NUM_DIGITS - 1)));
    state_d = !enable ? IDLE :
              state_q == IDLE ? BLANK :
              state_q == BLANK ? (blank_end ? DRIVE : BLANK) :
              (slot_end ? BLANK : DRIVE);
    idx_d = (!enable || state_q == IDLE) ? '0 :
            (state_q == DRIVE && slot_end) ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1) :
            idx_q;
    cnt_d = (state_d == IDLE || (state_d == BLANK && state_q != BLANK)) ? '0 : cnt_q + 1'b1;
    stage_d     = load ? digits_in : stage_q;
    stage_dp_d  = load ? dp_in : stage_dp_q;
    pending_d   = !boundary && (load || pending_q);
    // a load on the boundary itself bypasses staging so it shows this frame
    shadow_d    = (boundary && load) ? digits_in :
                  (boundary && pending_q) ? stage_q : shadow_q;
    shadow_dp_d = (boundary && load) ? dp_in :
                  (boundary && pending_q) ? stage_dp_q : shadow_dp_q;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero && shadow_q[4*k +: 4] == 4'h0;
      lz_mask[k] = lz_blank && all_zero && k != 0;
    end
    drive = state_d == DRIVE;
    an_d  = drive ? NUM_DIGITS'(1) << idx_d : '0;
    seg_d = (drive && !lz_mask[idx_d]) ? glyph : SEG_OFF;
    dp_d  = drive && shadow_dp_q[idx_d];
  end
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      stage_dp_q  <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pending_q   <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      an          <= {NUM_DIGITS{ACTIVE_LOW}};
      seg         <= {7{ACTIVE_LOW}};
      dp          <= ACTIVE_LOW;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      stage_dp_q  <= stage_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      load_ack    <= boundary && (load || pending_q);
      frame_start <= boundary;
      an          <= an_d ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg         <= seg_d ^ {7{ACTIVE_LOW}};
      dp          <= dp_d ^ ACTIVE_LOW;
    end
  end
endmodule
